// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I pipeline: word width, the bubble
// instruction, reset PC and the fetch FSM state encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0 - the canonical NOP used to fill bubbles
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  // REQ : request outstanding, waiting for the response
  // HOLD: response parked in the one-entry buffer while IF/ID is stalled
  // DROP: a redirect orphaned an outstanding request; swallow its response
  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_HOLD = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

  // Force an address onto a 4-byte boundary
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: PC, instruction and valid bit. A flush loads a
// bubble (PC 0, NOP, valid 0) and takes priority over a normal write.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] instr_in,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] instr_out,
  output logic            valid_out
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;

  // Next-value selection: flush beats write, otherwise hold
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (flush) begin
      pc_d    = '0;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (we) begin
      pc_d    = pc_in;
      instr_d = instr_in;
      valid_d = 1'b1;
    end
  end

  // Register update with asynchronous reset to a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_out    = pc_q;
  assign instr_out = instr_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues one instruction-memory request at a time,
// parks a response when decode is stalled and discards responses that a
// branch redirect has made stale.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PCWrite,
  input  logic            IF_ID_Write,
  input  logic            branch_taken_ID,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] IF_ID_PC,
  output logic [XLEN-1:0] IF_ID_Instr,
  output logic            IF_ID_Valid,
  output logic            misalign_err,
  output logic [1:0]      dbg_state
);

  // Memory handshake: imem_req high means a request for imem_addr is
  // outstanding; imem_addr is frozen until imem_rvalid returns, which may
  // happen in the same cycle req rises. Exactly one request is in flight,
  // and a response owed to a request abandoned by a redirect (DROP) still
  // arrives while imem_req is low and is thrown away.

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] buf_pc_q, buf_pc_d;
  logic [XLEN-1:0] buf_instr_q, buf_instr_d;
  logic            buf_valid_q, buf_valid_d;
  logic            misalign_q, misalign_d;

  logic            ifid_we;
  logic            ifid_flush;
  logic [XLEN-1:0] ifid_pc_in;
  logic [XLEN-1:0] ifid_instr_in;

  logic [XLEN-1:0] pc_plus4;
  assign pc_plus4 = pc_q + 32'd4;  // wraps modulo 2^32

  // Next-state, PC, buffer and IF/ID control: redirect > stall > delivery
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    buf_pc_d      = buf_pc_q;
    buf_instr_d   = buf_instr_q;
    buf_valid_d   = buf_valid_q;
    misalign_d    = 1'b0;
    ifid_we       = 1'b0;
    ifid_flush    = 1'b0;
    ifid_pc_in    = pc_q;
    ifid_instr_in = imem_rdata;

    if (branch_taken_ID) begin
      pc_d        = align_word(branch_target);
      ifid_flush  = 1'b1;
      buf_valid_d = 1'b0;
      misalign_d  = |branch_target[1:0];
      unique case (state_q)
        FETCH_REQ:  state_d = imem_rvalid ? FETCH_REQ : FETCH_DROP;
        FETCH_HOLD: state_d = FETCH_REQ;
        FETCH_DROP: state_d = imem_rvalid ? FETCH_REQ : FETCH_DROP;
        default:    state_d = FETCH_REQ;
      endcase
    end else begin
      unique case (state_q)
        FETCH_REQ: begin
          if (imem_rvalid) begin
            if (IF_ID_Write) begin
              ifid_we = 1'b1;
              if (PCWrite) pc_d = pc_plus4;
            end else begin
              // Decode is stalled: park the response instead of losing it
              buf_pc_d    = pc_q;
              buf_instr_d = imem_rdata;
              buf_valid_d = 1'b1;
              state_d     = FETCH_HOLD;
            end
          end else if (IF_ID_Write) begin
            ifid_flush = 1'b1;  // nothing arrived: hand decode a bubble
          end
        end
        FETCH_HOLD: begin
          if (IF_ID_Write) begin
            ifid_we       = 1'b1;
            ifid_pc_in    = buf_pc_q;
            ifid_instr_in = buf_instr_q;
            buf_valid_d   = 1'b0;
            if (PCWrite) pc_d = pc_plus4;
            state_d = FETCH_REQ;
          end
        end
        FETCH_DROP: begin
          if (imem_rvalid) state_d = FETCH_REQ;
        end
        default: state_d = FETCH_REQ;
      endcase
    end

    req_d = (state_d == FETCH_REQ);
  end

  // FSM, PC, request, buffer and error-pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FETCH_REQ;
      pc_q        <= RESET_PC;
      req_q       <= 1'b1;
      buf_pc_q    <= '0;
      buf_instr_q <= NOP_INSTR;
      buf_valid_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_q       <= req_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
      buf_valid_q <= buf_valid_d;
      misalign_q  <= misalign_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .reset     (reset),
    .we        (ifid_we),
    .flush     (ifid_flush),
    .pc_in     (ifid_pc_in),
    .instr_in  (ifid_instr_in),
    .pc_out    (IF_ID_PC),
    .instr_out (IF_ID_Instr),
    .valid_out (IF_ID_Valid)
  );

  assign imem_req     = req_q;
  assign imem_addr    = pc_q;
  assign misalign_err = misalign_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a small instruction memory model with
// configurable latency (or manual response control) and one task per scenario.
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        PCWrite;
  logic        IF_ID_Write;
  logic        branch_taken_ID;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] IF_ID_PC;
  logic [31:0] IF_ID_Instr;
  logic        IF_ID_Valid;
  logic        misalign_err;
  logic [1:0]  dbg_state;

  int n_pass;
  int n_total;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .PCWrite         (PCWrite),
    .IF_ID_Write     (IF_ID_Write),
    .branch_taken_ID (branch_taken_ID),
    .branch_target   (branch_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .IF_ID_PC        (IF_ID_PC),
    .IF_ID_Instr     (IF_ID_Instr),
    .IF_ID_Valid     (IF_ID_Valid),
    .misalign_err    (misalign_err),
    .dbg_state       (dbg_state)
  );

  // ---------------- memory model ----------------
  // Instruction word tagged with its address so each fetch is identifiable
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {8'hAB, a[23:0]};
  endfunction

  logic        mem_auto;     // 1: latency model drives the response, 0: manual
  int          mem_lat;      // 0: rvalid in the same cycle as req
  logic        man_rvalid;
  logic [31:0] man_rdata;
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr_q;
  logic        model_rvalid;
  logic [31:0] model_rdata;

  always_comb begin
    model_rvalid = 1'b0;
    model_rdata  = instr_of(imem_addr);
    if (mem_lat == 0) model_rvalid = imem_req;
    else              model_rvalid = mem_busy && (mem_cnt == mem_lat);
    if (mem_busy) model_rdata = instr_of(mem_addr_q);
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_busy   <= 1'b0;
      mem_cnt    <= 0;
      mem_addr_q <= '0;
    end else if (mem_auto && mem_lat > 0) begin
      if (!mem_busy && imem_req) begin
        mem_busy   <= 1'b1;
        mem_cnt    <= 1;
        mem_addr_q <= imem_addr;
      end else if (mem_busy) begin
        if (mem_cnt == mem_lat) mem_busy <= 1'b0;
        else                    mem_cnt  <= mem_cnt + 1;
      end
    end
  end

  assign imem_rvalid = mem_auto ? model_rvalid : man_rvalid;
  assign imem_rdata  = mem_auto ? model_rdata  : man_rdata;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drive_idle();
    PCWrite         = 1'b1;
    IF_ID_Write     = 1'b1;
    branch_taken_ID = 1'b0;
    branch_target   = '0;
    mem_auto        = 1'b1;
    man_rvalid      = 1'b0;
    man_rdata       = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(posedge clk);
    #1;
    n_total++; if (IF_ID_PC !== 32'h0) $display("FAIL rst_if_id_pc got=%h exp=%h", IF_ID_PC, 32'h0); else n_pass++;
    n_total++; if (IF_ID_Instr !== NOP) $display("FAIL rst_if_id_instr got=%h exp=%h", IF_ID_Instr, NOP); else n_pass++;
    n_total++; if (IF_ID_Valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", IF_ID_Valid); else n_pass++;
    n_total++; if (misalign_err !== 1'b0) $display("FAIL rst_misalign got=%b exp=0", misalign_err); else n_pass++;
    n_total++; if (imem_req !== 1'b1) $display("FAIL rst_req got=%b exp=1", imem_req); else n_pass++;
    n_total++; if (imem_addr !== 32'h0) $display("FAIL rst_addr got=%h exp=0", imem_addr); else n_pass++;
    n_total++; if (dbg_state !== FETCH_REQ) $display("FAIL rst_state got=%0d exp=%0d", dbg_state, FETCH_REQ); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] e;
    for (int k = 1; k <= 6; k++) begin
      tick();
      e = 32'(4 * (k - 1));
      n_total++; if (IF_ID_PC !== e) $display("FAIL stream_pc k=%0d got=%h exp=%h", k, IF_ID_PC, e); else n_pass++;
      n_total++; if (IF_ID_Instr !== instr_of(e)) $display("FAIL stream_instr k=%0d got=%h exp=%h", k, IF_ID_Instr, instr_of(e)); else n_pass++;
      n_total++; if (IF_ID_Valid !== 1'b1) $display("FAIL stream_valid k=%0d got=%b exp=1", k, IF_ID_Valid); else n_pass++;
    end
  endtask

  task automatic test_latency2();
    logic [31:0] e;
    drive_idle();
    mem_lat = 1;
    apply_reset();
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k % 2 == 1) begin
        n_total++; if (IF_ID_Valid !== 1'b0) $display("FAIL lat2_bubble k=%0d got=%b exp=0", k, IF_ID_Valid); else n_pass++;
        n_total++; if (IF_ID_Instr !== NOP) $display("FAIL lat2_nop k=%0d got=%h exp=%h", k, IF_ID_Instr, NOP); else n_pass++;
      end else begin
        e = 32'(4 * (k / 2 - 1));
        n_total++; if (IF_ID_Valid !== 1'b1) $display("FAIL lat2_valid k=%0d got=%b exp=1", k, IF_ID_Valid); else n_pass++;
        n_total++; if (IF_ID_PC !== e) $display("FAIL lat2_pc k=%0d got=%h exp=%h", k, IF_ID_PC, e); else n_pass++;
        n_total++; if (IF_ID_Instr !== instr_of(e)) $display("FAIL lat2_instr k=%0d got=%h exp=%h", k, IF_ID_Instr, instr_of(e)); else n_pass++;
      end
    end
    mem_lat = 0;
  endtask

  task automatic test_stall();
    drive_idle();
    mem_lat = 0;
    apply_reset();
    for (int k = 1; k <= 4; k++) tick();
    n_total++; if (IF_ID_PC !== 32'h0C) $display("FAIL stall_pre_pc got=%h exp=0000000c", IF_ID_PC); else n_pass++;
    IF_ID_Write = 1'b0;
    PCWrite     = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_total++; if (IF_ID_PC !== 32'h0C) $display("FAIL stall_hold_pc k=%0d got=%h exp=0000000c", k, IF_ID_PC); else n_pass++;
      n_total++; if (IF_ID_Valid !== 1'b1) $display("FAIL stall_hold_valid k=%0d got=%b exp=1", k, IF_ID_Valid); else n_pass++;
      n_total++; if (dbg_state !== FETCH_HOLD) $display("FAIL stall_state k=%0d got=%0d exp=%0d", k, dbg_state, FETCH_HOLD); else n_pass++;
      n_total++; if (imem_req !== 1'b0) $display("FAIL stall_req k=%0d got=%b exp=0", k, imem_req); else n_pass++;
      n_total++; if (imem_addr !== 32'h10) $display("FAIL stall_addr k=%0d got=%h exp=00000010", k, imem_addr); else n_pass++;
    end
    IF_ID_Write = 1'b1;
    PCWrite     = 1'b1;
    tick();
    n_total++; if (IF_ID_PC !== 32'h10) $display("FAIL stall_rel_pc0 got=%h exp=00000010", IF_ID_PC); else n_pass++;
    n_total++; if (IF_ID_Instr !== instr_of(32'h10)) $display("FAIL stall_rel_instr0 got=%h exp=%h", IF_ID_Instr, instr_of(32'h10)); else n_pass++;
    tick();
    n_total++; if (IF_ID_PC !== 32'h14) $display("FAIL stall_rel_pc1 got=%h exp=00000014", IF_ID_PC); else n_pass++;
    n_total++; if (IF_ID_Valid !== 1'b1) $display("FAIL stall_rel_valid1 got=%b exp=1", IF_ID_Valid); else n_pass++;
  endtask

  task automatic test_redirect_drop();
    drive_idle();
    mem_lat = 0;
    apply_reset();
    for (int k = 1; k <= 8; k++) tick();
    n_total++; if (imem_addr !== 32'h20) $display("FAIL drop_pre_addr got=%h exp=00000020", imem_addr); else n_pass++;
    // request for 0x20 now outstanding with no response; branch arrives
    mem_auto        = 1'b0;
    man_rvalid      = 1'b0;
    branch_taken_ID = 1'b1;
    branch_target   = 32'h80;
    tick();
    branch_taken_ID = 1'b0;
    n_total++; if (dbg_state !== FETCH_DROP) $display("FAIL drop_state got=%0d exp=%0d", dbg_state, FETCH_DROP); else n_pass++;
    n_total++; if (imem_req !== 1'b0) $display("FAIL drop_req got=%b exp=0", imem_req); else n_pass++;
    n_total++; if (imem_addr !== 32'h80) $display("FAIL drop_addr got=%h exp=00000080", imem_addr); else n_pass++;
    n_total++; if (IF_ID_Valid !== 1'b0) $display("FAIL drop_flush got=%b exp=0", IF_ID_Valid); else n_pass++;
    tick();
    n_total++; if (dbg_state !== FETCH_DROP) $display("FAIL drop_wait_state got=%0d exp=%0d", dbg_state, FETCH_DROP); else n_pass++;
    man_rvalid = 1'b1;
    man_rdata  = instr_of(32'h20);
    tick();
    man_rvalid = 1'b0;
    n_total++; if (dbg_state !== FETCH_REQ) $display("FAIL drop_done_state got=%0d exp=%0d", dbg_state, FETCH_REQ); else n_pass++;
    n_total++; if (IF_ID_Valid !== 1'b0) $display("FAIL drop_discard got=%b exp=0", IF_ID_Valid); else n_pass++;
    n_total++; if (imem_req !== 1'b1) $display("FAIL drop_refetch_req got=%b exp=1", imem_req); else n_pass++;
    mem_auto = 1'b1;
    tick();
    n_total++; if (IF_ID_PC !== 32'h80) $display("FAIL drop_next_pc got=%h exp=00000080", IF_ID_PC); else n_pass++;
    n_total++; if (IF_ID_Instr !== instr_of(32'h80)) $display("FAIL drop_next_instr got=%h exp=%h", IF_ID_Instr, instr_of(32'h80)); else n_pass++;
    n_total++; if (IF_ID_Valid !== 1'b1) $display("FAIL drop_next_valid got=%b exp=1", IF_ID_Valid); else n_pass++;
  endtask

  task automatic test_redirect_misalign();
    drive_idle();
    mem_lat = 0;
    apply_reset();
    for (int k = 1; k <= 3; k++) tick();
    branch_taken_ID = 1'b1;
    branch_target   = 32'h83;
    PCWrite         = 1'b0;
    IF_ID_Write     = 1'b0;
    tick();
    branch_taken_ID = 1'b0;
    PCWrite         = 1'b1;
    IF_ID_Write     = 1'b1;
    n_total++; if (imem_addr !== 32'h80) $display("FAIL mis_addr got=%h exp=00000080", imem_addr); else n_pass++;
    n_total++; if (IF_ID_Valid !== 1'b0) $display("FAIL mis_valid got=%b exp=0", IF_ID_Valid); else n_pass++;
    n_total++; if (IF_ID_Instr !== NOP) $display("FAIL mis_nop got=%h exp=%h", IF_ID_Instr, NOP); else n_pass++;
    n_total++; if (misalign_err !== 1'b1) $display("FAIL mis_pulse got=%b exp=1", misalign_err); else n_pass++;
    n_total++; if (dbg_state !== FETCH_REQ) $display("FAIL mis_state got=%0d exp=%0d", dbg_state, FETCH_REQ); else n_pass++;
    tick();
    n_total++; if (misalign_err !== 1'b0) $display("FAIL mis_pulse_end got=%b exp=0", misalign_err); else n_pass++;
    n_total++; if (IF_ID_PC !== 32'h80) $display("FAIL mis_pc0 got=%h exp=00000080", IF_ID_PC); else n_pass++;
    tick();
    n_total++; if (IF_ID_PC !== 32'h84) $display("FAIL mis_pc1 got=%h exp=00000084", IF_ID_PC); else n_pass++;
  endtask

  task automatic test_wrap();
    drive_idle();
    mem_lat = 0;
    apply_reset();
    tick();
    branch_taken_ID = 1'b1;
    branch_target   = 32'hFFFF_FFFC;
    tick();
    branch_taken_ID = 1'b0;
    n_total++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr got=%h exp=fffffffc", imem_addr); else n_pass++;
    n_total++; if (misalign_err !== 1'b0) $display("FAIL wrap_misalign got=%b exp=0", misalign_err); else n_pass++;
    tick();
    n_total++; if (IF_ID_PC !== 32'hFFFF_FFFC) $display("FAIL wrap_ifid_pc got=%h exp=fffffffc", IF_ID_PC); else n_pass++;
    n_total++; if (imem_addr !== 32'h0) $display("FAIL wrap_next_addr got=%h exp=00000000", imem_addr); else n_pass++;
    tick();
    n_total++; if (IF_ID_PC !== 32'h0) $display("FAIL wrap_ifid_pc0 got=%h exp=00000000", IF_ID_PC); else n_pass++;
  endtask

  task automatic test_reset_mid_hold();
    drive_idle();
    mem_lat = 0;
    apply_reset();
    for (int k = 1; k <= 3; k++) tick();
    IF_ID_Write = 1'b0;
    tick();
    n_total++; if (dbg_state !== FETCH_HOLD) $display("FAIL rsth_pre_state got=%0d exp=%0d", dbg_state, FETCH_HOLD); else n_pass++;
    n_total++; if (IF_ID_PC !== 32'h08) $display("FAIL rsth_pre_pc got=%h exp=00000008", IF_ID_PC); else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_total++; if (dbg_state !== FETCH_REQ) $display("FAIL rsth_state got=%0d exp=%0d", dbg_state, FETCH_REQ); else n_pass++;
    n_total++; if (imem_req !== 1'b1) $display("FAIL rsth_req got=%b exp=1", imem_req); else n_pass++;
    n_total++; if (imem_addr !== 32'h0) $display("FAIL rsth_addr got=%h exp=00000000", imem_addr); else n_pass++;
    n_total++; if (IF_ID_Valid !== 1'b0) $display("FAIL rsth_valid got=%b exp=0", IF_ID_Valid); else n_pass++;
    n_total++; if (IF_ID_Instr !== NOP) $display("FAIL rsth_instr got=%h exp=%h", IF_ID_Instr, NOP); else n_pass++;
    n_total++; if (IF_ID_PC !== 32'h0) $display("FAIL rsth_pc got=%h exp=00000000", IF_ID_PC); else n_pass++;
    #1 reset = 1'b0;
    IF_ID_Write = 1'b1;
    tick();
    n_total++; if (IF_ID_PC !== 32'h0 || IF_ID_Valid !== 1'b1) $display("FAIL rsth_refetch0 got=%h/%b exp=00000000/1", IF_ID_PC, IF_ID_Valid); else n_pass++;
    tick();
    n_total++; if (IF_ID_PC !== 32'h4) $display("FAIL rsth_refetch1 got=%h exp=00000004", IF_ID_PC); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    mem_lat = 0;
    drive_idle();
    test_reset();
    test_stream();
    test_latency2();
    test_stall();
    test_redirect_drop();
    test_redirect_misalign();
    test_wrap();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
